// File: rtl/sprite_capture_writer.sv
// Window-capture writer: arms on capture_in, waits for a frame start, then writes
// every in-window palette index of the live stream into the sprite image BRAM.
module sprite_capture_writer #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic                                pixel_clk_in,
    input  logic                                rst_in,
    input  logic                                capture_in,
    input  logic [10:0]                         x_in,
    input  logic [9:0]                          y_in,
    input  logic [10:0]                         hcount_in,
    input  logic [9:0]                          vcount_in,
    input  logic                                data_valid_in,
    input  logic [7:0]                          pixel_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]     addr_out,
    output logic [7:0]                          data_out,
    output logic                                we_out,
    output logic                                busy_out,
    output logic                                done_out,
    output logic                                partial_out
);

    localparam int              AW       = $clog2(WIDTH*HEIGHT);
    localparam int              CW       = $clog2(WIDTH*HEIGHT + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH*HEIGHT - 1);
    localparam logic [11:0]     W12      = 12'(WIDTH);
    localparam logic [10:0]     H11      = 11'(HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

    state_t          state_q, state_d;
    logic [10:0]     x0_q, x0_d;
    logic [9:0]      y0_q, y0_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            we_q, we_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            partial_q, partial_d;

    // Bounds are widened by one bit so x0+WIDTH and y0+HEIGHT never wrap.
    logic [11:0]     hx, xs, xe, dx;
    logic [10:0]     vy, ys, ye, dy;
    logic            frame_start, in_win, is_last;

    always_comb begin
        hx          = {1'b0, hcount_in};
        xs          = {1'b0, x0_q};
        xe          = xs + W12;
        dx          = hx - xs;
        vy          = {1'b0, vcount_in};
        ys          = {1'b0, y0_q};
        ye          = ys + H11;
        dy          = vy - ys;
        frame_start = data_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        in_win      = data_valid_in && (hx >= xs) && (hx < xe) && (vy >= ys) && (vy < ye);
        is_last     = (hx == xe - 12'd1) && (vy == ye - 11'd1);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        partial_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A request coinciding with the done pulse is dropped.
                if (capture_in && !done_q) begin
                    state_d = S_ARMED;
                    x0_d    = x_in;
                    y0_d    = y_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_ARMED, S_CAPTURE: begin
                if (state_q == S_CAPTURE && frame_start) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    partial_d = 1'b1;
                    busy_d    = 1'b0;
                end else if (state_q == S_CAPTURE || frame_start) begin
                    state_d = S_CAPTURE;
                    if (in_win) begin
                        we_d   = 1'b1;
                        // Modular arithmetic at AW bits equals truncating the full sum.
                        addr_d = AW'(dx) + AW'(dy) * AW'(WIDTH);
                        data_d = pixel_in;
                        cnt_d  = cnt_q + CW'(1);
                        if (is_last && cnt_q == LAST_CNT) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        // NOTE: state uses non-blocking assignments so all registers update together.
        if (rst_in) begin
            state_q   <= S_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            partial_q <= partial_d;
        end
    end

    assign addr_out    = addr_q;
    assign data_out    = data_q;
    assign we_out      = we_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign partial_out = partial_q;

endmodule

// File: tb/tb_sprite_capture_writer.sv
// Bench for sprite_capture_writer: three instances (4x2, 4x4, 256x256) share one
// sparse timed stream; a reference model fills per-instance scoreboards.
module tb_sprite_capture_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_a_x;
    logic        cap_a, cap_b, cap_c;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        dv;
    logic [7:0]  pix;
    wire         rst_a = rst | rst_a_x;

    logic [2:0]  a_addr;  logic [7:0] a_data; logic a_we, a_busy, a_done, a_part;
    logic [3:0]  b_addr;  logic [7:0] b_data; logic b_we, b_busy, b_done, b_part;
    logic [15:0] c_addr;  logic [7:0] c_data; logic c_we, c_busy, c_done, c_part;

    sprite_capture_writer #(.WIDTH(4), .HEIGHT(2)) dut_a (
        .pixel_clk_in(clk), .rst_in(rst_a), .capture_in(cap_a), .x_in(x_in), .y_in(y_in),
        .hcount_in(hc), .vcount_in(vc), .data_valid_in(dv), .pixel_in(pix),
        .addr_out(a_addr), .data_out(a_data), .we_out(a_we), .busy_out(a_busy),
        .done_out(a_done), .partial_out(a_part));

    sprite_capture_writer #(.WIDTH(4), .HEIGHT(4)) dut_b (
        .pixel_clk_in(clk), .rst_in(rst), .capture_in(cap_b), .x_in(x_in), .y_in(y_in),
        .hcount_in(hc), .vcount_in(vc), .data_valid_in(dv), .pixel_in(pix),
        .addr_out(b_addr), .data_out(b_data), .we_out(b_we), .busy_out(b_busy),
        .done_out(b_done), .partial_out(b_part));

    sprite_capture_writer dut_c (
        .pixel_clk_in(clk), .rst_in(rst), .capture_in(cap_c), .x_in(x_in), .y_in(y_in),
        .hcount_in(hc), .vcount_in(vc), .data_valid_in(dv), .pixel_in(pix),
        .addr_out(c_addr), .data_out(c_data), .we_out(c_we), .busy_out(c_busy),
        .done_out(c_done), .partial_out(c_part));

    typedef struct {
        logic we;
        int   addr;
        int   data;
        logic done;
        logic partial;
    } ev_t;

    ev_t qa[$], qb[$], qc[$];

    int m_st [3];
    int m_x0 [3];
    int m_y0 [3];
    int m_cnt[3];
    int m_w  [3] = '{4, 4, 256};
    int m_h  [3] = '{2, 4, 256};

    int n_cmp = 0;
    int n_err = 0;
    int c_done_n = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_ev(input string n, input ev_t e, input logic we, input logic [31:0] addr,
                            input logic [7:0] data, input logic done, input logic part,
                            input logic busy);
        check({n, "_we"}, 32'(we), 32'(e.we));
        if (e.we) begin
            check({n, "_addr"}, addr, e.addr);
            check({n, "_data"}, 32'(data), e.data);
        end
        check({n, "_done"}, 32'(done), 32'(e.done));
        check({n, "_partial"}, 32'(part), 32'(e.partial));
        check({n, "_busy"}, 32'(busy), 32'(!e.done));
    endtask

    task automatic push_ev(input int id, input ev_t e);
        case (id)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    // Reference behaviour of one pixel cycle for instance id.
    task automatic model_pixel(input int id, input int h, input int v, input bit valid, input int p);
        bit  fs;
        ev_t e;
        fs = valid && h == 0 && v == 0;
        if (m_st[id] == 2 && fs) begin
            e = '{we: 1'b0, addr: 0, data: 0, done: 1'b1, partial: 1'b1};
            push_ev(id, e);
            m_st[id] = 0;
        end else if (m_st[id] == 2 || (m_st[id] == 1 && fs)) begin
            m_st[id] = 2;
            if (valid && h >= m_x0[id] && h < m_x0[id] + m_w[id] &&
                v >= m_y0[id] && v < m_y0[id] + m_h[id]) begin
                m_cnt[id]++;
                e.we      = 1'b1;
                e.addr    = (h - m_x0[id]) + (v - m_y0[id]) * m_w[id];
                e.data    = p % 256;
                e.partial = 1'b0;
                e.done    = (h == m_x0[id] + m_w[id] - 1) && (v == m_y0[id] + m_h[id] - 1) &&
                            (m_cnt[id] == m_w[id] * m_h[id]);
                if (e.done) m_st[id] = 0;
                push_ev(id, e);
            end
        end
    endtask

    task automatic model_capture(input int id, input int x, input int y);
        if (m_st[id] == 0) begin
            m_st[id]  = 1;
            m_x0[id]  = x;
            m_y0[id]  = y;
            m_cnt[id] = 0;
        end
    endtask

    task automatic tick(input int h, input int v, input bit valid, input bit [2:0] caps,
                        input int cx, input int cy, input bit ra);
        @(posedge clk);
        #1;
        hc      = 11'(h);
        vc      = 10'(v);
        dv      = valid;
        pix     = 8'(h);
        cap_a   = caps[0];
        cap_b   = caps[1];
        cap_c   = caps[2];
        x_in    = 11'(cx);
        y_in    = 10'(cy);
        rst_a_x = ra;
        for (int id = 0; id < 3; id++) begin
            if (!(id == 0 && ra)) begin
                model_pixel(id, h, v, valid, h);
                if (caps[id]) model_capture(id, cx, cy);
            end
        end
        if (ra) m_st[0] = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 1'b0, 3'b000, 0, 0, 1'b0);
    endtask

    task automatic frame(input int vlo, input int vhi, input int hlo, input int hhi,
                         input int dh, input int dvv);
        tick(0, 0, 1'b1, 3'b000, 0, 0, 1'b0);
        for (int v = vlo; v <= vhi; v++)
            for (int h = hlo; h <= hhi; h++)
                if (!(h == 0 && v == 0))
                    tick(h, v, !(h == dh && v == dvv), 3'b000, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin : mon_a
        ev_t e;
        if (a_we === 1'b1 || a_done === 1'b1) begin
            if (qa.size() == 0) check("a_spurious", 32'(a_we | a_done), 32'd0);
            else begin
                e = qa.pop_front();
                check_ev("a", e, a_we, 32'(a_addr), a_data, a_done, a_part, a_busy);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t e;
        if (b_we === 1'b1 || b_done === 1'b1) begin
            if (qb.size() == 0) check("b_spurious", 32'(b_we | b_done), 32'd0);
            else begin
                e = qb.pop_front();
                check_ev("b", e, b_we, 32'(b_addr), b_data, b_done, b_part, b_busy);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        ev_t e;
        if (c_done === 1'b1) c_done_n++;
        if (c_we === 1'b1 || c_done === 1'b1) begin
            if (qc.size() == 0) check("c_spurious", 32'(c_we | c_done), 32'd0);
            else begin
                e = qc.pop_front();
                check_ev("c", e, c_we, 32'(c_addr), c_data, c_done, c_part, c_busy);
            end
        end
    end

    initial begin
        rst = 1'b1; rst_a_x = 1'b0;
        cap_a = 1'b0; cap_b = 1'b0; cap_c = 1'b0;
        x_in = '0; y_in = '0; hc = '0; vc = '0; dv = 1'b0; pix = '0;
        for (int i = 0; i < 3; i++) begin m_st[i] = 0; m_x0[i] = 0; m_y0[i] = 0; m_cnt[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(a_addr), 0);
        check("rst_data", 32'(a_data), 0);
        check("rst_we", 32'(a_we), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_partial", 32'(a_part), 0);
        check("rst_busy_b", 32'(b_busy), 0);
        check("rst_we_c", 32'(c_we), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Normal 4x2 capture at (10,5).
        tick(0, 0, 1'b0, 3'b001, 10, 5, 1'b0);
        idle(1);
        @(negedge clk);
        check("t1_busy_rise", 32'(a_busy), 1);
        frame(0, 7, 0, 15, -1, -1);
        idle(3);
        @(negedge clk);
        check("t1_busy_fall", 32'(a_busy), 0);
        check("t1_drain", qa.size(), 0);

        // Pixel (12,5) invalid: no normal finish, next frame start clips.
        tick(0, 0, 1'b0, 3'b001, 10, 5, 1'b0);
        frame(0, 7, 0, 15, 12, 5);
        idle(3);
        @(negedge clk);
        check("t2_still_busy", 32'(a_busy), 1);
        check("t2_drain_mid", qa.size(), 0);
        tick(0, 0, 1'b1, 3'b000, 0, 0, 1'b0);
        idle(3);
        @(negedge clk);
        check("t2_busy_fall", 32'(a_busy), 0);
        check("t2_drain", qa.size(), 0);

        // 4x4 window at (638,478) clipped by the visible area.
        tick(0, 0, 1'b0, 3'b010, 638, 478, 1'b0);
        idle(1);
        frame(476, 479, 636, 639, -1, -1);
        idle(3);
        @(negedge clk);
        check("t3_still_busy", 32'(b_busy), 1);
        check("t3_drain_mid", qb.size(), 0);
        tick(0, 0, 1'b1, 3'b000, 0, 0, 1'b0);
        idle(3);
        @(negedge clk);
        check("t3_busy_fall", 32'(b_busy), 0);
        check("t3_drain", qb.size(), 0);

        // Second capture while armed must be ignored.
        tick(0, 0, 1'b0, 3'b001, 10, 5, 1'b0);
        idle(1);
        tick(0, 0, 1'b0, 3'b001, 0, 0, 1'b0);
        idle(1);
        @(negedge clk);
        check("t4_busy_held", 32'(a_busy), 1);
        frame(0, 7, 0, 15, -1, -1);
        idle(3);
        @(negedge clk);
        check("t4_busy_fall", 32'(a_busy), 0);
        check("t4_drain", qa.size(), 0);

        // Reset mid-row, then a fresh capture.
        tick(0, 0, 1'b0, 3'b001, 10, 5, 1'b0);
        idle(1);
        tick(0, 0, 1'b1, 3'b000, 0, 0, 1'b0);
        for (int h = 0; h < 12; h++) tick(h, 5, 1'b1, 3'b000, 0, 0, 1'b0);
        tick(12, 5, 1'b1, 3'b000, 0, 0, 1'b1);
        tick(13, 5, 1'b1, 3'b000, 0, 0, 1'b0);
        @(negedge clk);
        check("t5_addr", 32'(a_addr), 0);
        check("t5_data", 32'(a_data), 0);
        check("t5_we", 32'(a_we), 0);
        check("t5_busy", 32'(a_busy), 0);
        check("t5_done", 32'(a_done), 0);
        check("t5_partial", 32'(a_part), 0);
        for (int h = 14; h < 16; h++) tick(h, 5, 1'b1, 3'b000, 0, 0, 1'b0);
        for (int h = 0; h < 16; h++) tick(h, 6, 1'b1, 3'b000, 0, 0, 1'b0);
        idle(3);
        check("t5_drain_rst", qa.size(), 0);
        tick(0, 0, 1'b0, 3'b001, 10, 5, 1'b0);
        frame(0, 7, 0, 15, -1, -1);
        idle(3);
        @(negedge clk);
        check("t5_busy_fall", 32'(a_busy), 0);
        check("t5_drain", qa.size(), 0);

        // Default 256x256 window at the origin.
        tick(0, 0, 1'b0, 3'b100, 0, 0, 1'b0);
        idle(1);
        frame(0, 255, 0, 255, -1, -1);
        idle(3);
        @(negedge clk);
        check("t6_busy_fall", 32'(c_busy), 0);
        check("t6_drain", qc.size(), 0);
        check("t6_done_once", c_done_n, 1);
        tick(0, 0, 1'b1, 3'b000, 0, 0, 1'b0);
        idle(3);
        @(negedge clk);
        check("t6_done_once_after", c_done_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_capture_writer.md
# sprite_capture_writer

Window-capture writer that fills the sprite image BRAM from a live pixel stream. It is the write-side counterpart of the sprite renderer, which reads 8-bit palette indices from the image BRAM at address (hcount − x) + (vcount − y)·WIDTH. On command, this block waits for the next frame start and writes each in-window palette index from the timed video stream to that same address. It then reports completion. It drives the write port (port A write enable/address/data) of the shared image BRAM.

## Interface
Parameters:
- WIDTH, 256, window width in pixels
- HEIGHT, 256, window height in pixels

Ports:
- pixel_clk_in  input  1  pixel clock; the only clock
- rst_in  input  1  synchronous, active-high reset
- capture_in  input  1  single-cycle request to arm a capture
- x_in  input  11  window left edge; sampled on an accepted capture_in
- y_in  input  10  window top edge; sampled on an accepted capture_in
- hcount_in  input  11  current pixel column of the stream
- vcount_in  input  10  current pixel row of the stream
- data_valid_in  input  1  stream pixel valid this cycle
- pixel_in  input  8  palette index of the current pixel
- addr_out  output  $clog2(WIDTH*HEIGHT)  BRAM write address
- data_out  output  8  BRAM write data
- we_out  output  1  BRAM write enable
- busy_out  output  1  capture armed or in progress
- done_out  output  1  one-cycle pulse when a capture finishes
- partial_out  output  1  valid with done_out; high when fewer than WIDTH·HEIGHT writes occurred

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE:
  - capture_in latches x_in and y_in into x0 and y0, clears the write counter, and moves to ARMED.
- ARMED:
  - Waits for a frame start, defined as data_valid_in && hcount_in==0 && vcount_in==0.
  - On a frame start, moves to CAPTURE and the frame-start pixel is itself processed as a CAPTURE pixel.
- CAPTURE: a pixel is in-window when all of the following hold.
  - data_valid_in is high.
  - x0 ≤ hcount_in < x0+WIDTH.
  - y0 ≤ vcount_in < y0+HEIGHT.
- Each in-window pixel produces exactly one write:
  - Address is (hcount_in−x0) + (vcount_in−y0)·WIDTH, truncated to the addr_out width.
  - Data is pixel_in.
  - The write counter increments.
- Window bound comparisons are done at 12 bits for x and 11 bits for y, so x0+WIDTH and y0+HEIGHT never wrap.
- The address may be produced by running row/column counters rather than a multiplier. It must match the formula bit-exactly.
- Normal finish: the in-window pixel at (x0+WIDTH−1, y0+HEIGHT−1) is written. Then done_out pulses with partial_out=0 and the state returns to IDLE.
- Clipped finish: a second frame start is seen in CAPTURE before the last pixel, for example when the window extends past the visible area.
  - That pixel is not written.
  - done_out pulses with partial_out=1 and the state returns to IDLE.
- capture_in in ARMED or CAPTURE is ignored; x0 and y0 do not change.
- capture_in in the same cycle done_out asserts is ignored.
- Reset mid-capture: the next cycle is IDLE with all outputs 0. No done_out is produced and any pending write is dropped.

## Timing
- Reset values:
  - addr_out=0, data_out=0, we_out=0, busy_out=0, done_out=0, partial_out=0.
  - State is IDLE; x0, y0 and the counter are 0.
- All outputs are registered.
- Write latency is 1 cycle: an in-window pixel at cycle N gives we_out/addr_out/data_out at N+1.
- we_out is high only in cycles following an in-window pixel. addr_out and data_out hold their last values when we_out=0.
- busy_out:
  - Rises the cycle after an accepted capture_in.
  - Falls in the same cycle done_out is high.
- done_out:
  - Normal finish: asserts in the same cycle as the final we_out.
  - Clipped finish: asserts the cycle after the terminating frame start.
- Throughput: one write per cycle, sustained; no back-pressure.

## Test plan
- WIDTH=4, HEIGHT=2, x_in=10, y_in=5, 640×480 stream with pixel_in=hcount[7:0]:
  - Exactly 8 writes: addr 0..3 with data 10..13, then addr 4..7 with data 10..13.
  - done_out=1 and partial_out=0 together with the write of addr 7; busy_out falls in that cycle.
- Same window, data_valid_in deasserted on pixel (12,5):
  - Addr 2 is never written.
  - No done_out until the next frame start, which gives done_out=1 and partial_out=1.
- WIDTH=4, HEIGHT=4, x_in=638, y_in=478 on a 640×480 stream:
  - Writes only addr 0, 1, 4 and 5.
  - done_out=1 and partial_out=1 one cycle after the next frame start.
- capture_in pulsed again in ARMED with x_in=0:
  - Writes still use the first x0=10.
  - busy_out stays high continuously.
- rst_in asserted for 1 cycle mid-row in CAPTURE:
  - All outputs 0 in the following cycle; no done_out.
  - A new capture_in then completes normally.
- Defaults 256×256 with x_in=0, y_in=0:
  - Writes 65536 entries, last at addr 65535 = (255,255).
  - done_out occurs exactly once.
